// File: rtl/led_pulse_driver_if.sv
// Event-in / LED-out signal bundle for led_pulse_driver.
// The master side is the event source (internal logic); the slave side is the driver.
interface led_pulse_driver_if #(
    parameter int PEND_W = 3
);
    logic              iIntEvt;
    logic              oExtLed;
    logic              oBusy;
    logic [PEND_W-1:0] oPend;
    logic              oOvf;

    modport master (
        output iIntEvt,
        input  oExtLed,
        input  oBusy,
        input  oPend,
        input  oOvf
    );

    modport slave (
        input  iIntEvt,
        output oExtLed,
        output oBusy,
        output oPend,
        output oOvf
    );
endinterface

// File: rtl/led_pulse_driver.sv
// Turns single-cycle event strobes into long active-low LED flashes.
// Each flash is followed by a minimum off gap. Events that arrive while a flash
// or gap is running are queued in a saturating counter and replayed one by one.
module led_pulse_driver #(
    parameter int ON_CYC  = 1350000,
    parameter int GAP_CYC = 1350000,
    parameter int PEND_W  = 3
) (
    input  logic              CLk,
    input  logic              RESET,
    led_pulse_driver_if.slave bus
);
    localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } state_t;

    state_t            state,  state_next;
    logic [TW-1:0]     timer,  timer_next;
    logic [PEND_W-1:0] pend,   pend_next;
    logic              ovf,    ovf_next;
    logic              led,    led_next;
    logic              busy,   busy_next;

    logic              evt;
    logic              timer_done;

    assign evt        = bus.iIntEvt;
    assign timer_done = (timer == '0);

    // Next-state logic: flash timing, queue accounting and registered output values.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_next = state;
        timer_next = timer;
        pend_next  = pend;
        ovf_next   = ovf;

        unique case (state)
            ST_IDLE: begin
                if (evt) begin
                    state_next = ST_ON;
                    timer_next = ON_LOAD;
                end
            end

            ST_ON: begin
                if (timer_done) begin
                    state_next = ST_GAP;
                    timer_next = GAP_LOAD;
                end else begin
                    timer_next = timer - TW'(1);
                end
                if (evt) begin
                    if (pend == PEND_MAX) ovf_next  = 1'b1;
                    else                  pend_next = pend + PEND_W'(1);
                end
            end

            ST_GAP: begin
                if (timer_done) begin
                    // A fresh event on the exit edge is consumed directly by the
                    // new flash, so the queue only drains when no event arrives.
                    if (evt || (pend != '0)) begin
                        state_next = ST_ON;
                        timer_next = ON_LOAD;
                        if (!evt) pend_next = pend - PEND_W'(1);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                    if (evt) begin
                        if (pend == PEND_MAX) ovf_next  = 1'b1;
                        else                  pend_next = pend + PEND_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase

        led_next  = (state_next != ST_ON);
        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge CLk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) begin
            state <= ST_IDLE;
            timer <= '0;
            pend  <= '0;
            ovf   <= 1'b0;
            led   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            pend  <= pend_next;
            ovf   <= ovf_next;
            led   <= led_next;
            busy  <= busy_next;
        end
    end

    assign bus.oExtLed = led;
    assign bus.oBusy   = busy;
    assign bus.oPend   = pend;
    assign bus.oOvf    = ovf;
endmodule

// File: tb/tb_led_pulse_driver.sv
// Scoreboard bench for led_pulse_driver (ON_CYC=4, GAP_CYC=3, PEND_W=2).
// The reference model is a timeline: each flash has a start cycle, and it is
// busy from that cycle until start+ON+GAP. Queued events start a new flash as
// soon as that window has passed.
module tb_led_pulse_driver;
    localparam int ON_CYC  = 4;
    localparam int GAP_CYC = 3;
    localparam int PEND_W  = 2;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    typedef struct {
        logic              led;
        logic              busy;
        logic [PEND_W-1:0] pend;
        logic              ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_pulse_driver_if #(.PEND_W(PEND_W)) bus ();

    led_pulse_driver #(
        .ON_CYC (ON_CYC),
        .GAP_CYC(GAP_CYC),
        .PEND_W (PEND_W)
    ) dut (
        .CLk  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model state.
    longint t      = 0;     // index of the clock edge being modelled
    longint fl_s   = -100;  // first LED-low cycle of the most recent flash
    int     m_pend = 0;
    bit     m_ovf  = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Apply the rules of one clock edge and return the outputs seen in the next cycle.
    task automatic model_edge(input bit evt, input bit r, output exp_t e);
        longint nxt;
        longint fin;
        nxt = t + 1;
        if (r) begin
            fl_s   = -100;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else begin
            fin = fl_s + ON_CYC + GAP_CYC;
            if (nxt >= fin && (evt || m_pend > 0)) begin
                fl_s = nxt;
                if (!evt) m_pend--;
            end else if (evt) begin
                if (m_pend == PEND_MAX) m_ovf = 1'b1;
                else                    m_pend++;
            end
        end
        e.led  = !(nxt >= fl_s && nxt < fl_s + ON_CYC);
        e.busy = (nxt >= fl_s && nxt < fl_s + ON_CYC + GAP_CYC);
        e.pend = PEND_W'(m_pend);
        e.ovf  = m_ovf;
        t++;
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic cyc(input bit evt, input bit r);
        exp_t e;
        bus.iIntEvt = evt;
        rst         = r;
        @(posedge clk);
        #1;
        model_edge(evt, r, e);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("led",  int'(bus.oExtLed), int'(mon_e.led));
            check("busy", int'(bus.oBusy),   int'(mon_e.busy));
            check("pend", int'(bus.oPend),   int'(mon_e.pend));
            check("ovf",  int'(bus.oOvf),    int'(mon_e.ovf));
        end
    end

    initial begin
        bus.iIntEvt = 1'b0;

        // Reset for two cycles, then a quiet period.
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        idle(12);

        // Single pulse.
        pulses(1);
        idle(12);

        // Two pulses two edges apart.
        pulses(1);
        idle(1);
        pulses(1);
        idle(20);

        // Five consecutive pulses: saturation and overflow, four flashes replayed.
        pulses(5);
        idle(40);

        // Clear overflow, then a pulse exactly on the gap-exit edge.
        cyc(1'b0, 1'b1);
        idle(3);
        pulses(1);
        idle(ON_CYC + GAP_CYC - 1);
        pulses(1);
        idle(20);

        // Reset mid-flash with two events queued.
        pulses(3);
        idle(1);
        cyc(1'b0, 1'b1);
        idle(20);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
        end
        idle(40);

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/led_pulse_driver.md
Name: led_pulse_driver

Overview:
- Output-direction counterpart of the button input path: turns single-cycle internal event pulses into visibly long, active-low flashes on an external LED pin.
- The pin is registered, idles high (LED off), and reset drives it high.
- Events arriving during a flash or the following gap are counted and replayed as separate flashes, so no event is lost up to a saturating limit.
- Sits between internal logic (e.g. a synchronised button path or status events) and a board LED pin.

Parameters:
- ON_CYC, 1350000, flash length in clock cycles; 50 ms at 27 MHz; must be >= 1.
- GAP_CYC, 1350000, minimum LED-off gap between consecutive flashes in cycles; must be >= 1.
- PEND_W, 3, width of the pending-event counter; saturates at 2^PEND_W-1.

Ports:
- CLk  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- iIntEvt  input  1  internal event strobe, already synchronous to CLk; each high cycle counts as one event.
- oExtLed  output  1  registered LED drive, active-low: 0 = on, 1 = off.
- oBusy  output  1  high while state is not IDLE.
- oPend  output  PEND_W  number of queued, not-yet-flashed events.
- oOvf  output  1  sticky flag: an event was dropped because the queue was saturated; cleared only by RESET.

Behaviour:
- Reset (RESET high at a rising edge): state=IDLE, oExtLed=1, oBusy=0, oPend=0, oOvf=0, timer=0.
  - Reset overrides everything, including an in-progress flash or a pending queue; those events are discarded.
- Timer: counts down, width clog2(max(ON_CYC,GAP_CYC)+1).
- State IDLE:
  - iIntEvt=1 at edge N moves to ON and loads timer with ON_CYC-1.
  - oExtLed=0 from edge N, i.e. visible in cycle N+1; latency is one clock.
- State ON:
  - oExtLed=0; timer decrements each cycle.
  - At timer==0 go to GAP, load GAP_CYC-1, oExtLed=1.
  - LED is therefore low for exactly ON_CYC cycles.
- State GAP:
  - oExtLed=1; timer decrements each cycle.
  - At timer==0:
    - if pending>0 (including an event in this same cycle): go to ON, reload ON_CYC-1, decrement pending by one (net 0 change if an event arrives this cycle);
    - otherwise go to IDLE.
  - LED is high for exactly GAP_CYC cycles between back-to-back flashes.
- Queueing in ON or GAP:
  - iIntEvt=1 increments pending, except in the GAP-exit cycle described above.
  - At saturation the increment is dropped and oOvf is set to 1.
- Simultaneous event and GAP-exit with pending=0: the event starts the next flash directly; pending stays 0 and no IDLE cycle is inserted.
- An event in the IDLE cycle immediately after GAP starts a flash at once; the gap has already been satisfied.
- Held-high iIntEvt counts one event per cycle. This is intended: callers must present pulses, not levels.
- oBusy=1 in ON and GAP.
- All outputs are registered; no combinational path from iIntEvt to oExtLed.

Test Plan (ON_CYC=4, GAP_CYC=3, PEND_W=2):
- Reset with RESET=1 for 2 cycles, then release with no events -> oExtLed=1, oBusy=0, oPend=0, oOvf=0 indefinitely.
- Single iIntEvt pulse at edge 10 -> oExtLed=0 for cycles 11-14, 1 from cycle 15; oBusy=1 for cycles 11-17, then 0.
- Two pulses at edges 10 and 12 -> first flash cycles 11-14, gap 15-17, second flash 18-21; oPend=1 from cycle 13 until the edge at end of cycle 17.
- Five pulses on consecutive edges 10-14 -> oPend saturates at 3 and oOvf=1 from cycle 15.
  - LED shows exactly 4 flashes, each 4 low cycles with 3 high cycles between, then IDLE; oOvf stays 1.
- Pulse exactly on the GAP-exit edge after the first flash, with oPend=0 -> next flash starts with no IDLE cycle and oPend stays 0.
- RESET asserted mid-flash with oPend=2 -> on the next cycle oExtLed=1, oPend=0, oBusy=0; no further flashes occur.
